// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul stream engine.
// MATMUL_STREAM_SAT_EN selects saturating accumulation in the PEs.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_OUTPUT
  } state_t;

  // Working width of sat_add; callers extend operands to this width.
  localparam int unsigned SAT_W = 64;

  // A beat entering PE(0,0) reaches PE(N-1,N-1) after 2(N-1) cycles, plus one to accumulate.
  function automatic int unsigned drain_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

  // Adds two values already sign/zero-extended to SAT_W and clamps to a width-bit range.
  function automatic logic [SAT_W-1:0] sat_add(
    input logic [SAT_W-1:0] acc,
    input logic [SAT_W-1:0] addend,
    input int unsigned      width,
    input logic             sgn
  );
    logic [SAT_W-1:0] sum;
    logic [SAT_W-1:0] hi;
    logic [SAT_W-1:0] lo;
    sum = acc + addend;
    if (sgn) begin
      hi = (SAT_W'(1) << (width - 1)) - SAT_W'(1);
      lo = ~hi;
      if ($signed(sum) > $signed(hi)) return hi;
      if ($signed(sum) < $signed(lo)) return lo;
    end else begin
      hi = (SAT_W'(1) << width) - SAT_W'(1);
      if (sum > hi) return hi;
    end
    return sum;
  endfunction

endpackage

// File: rtl/matmul_stream_engine_pe.sv
// One output-stationary MAC cell: forwards a east and b south, holds the accumulator.
// MATMUL_STREAM_SAT_EN makes the accumulator saturate and stay pinned at the limit.
module matmul_pe
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ACC_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 signed_mode,
  input  logic [DATA_SIZE-1:0] a_in,
  input  logic [DATA_SIZE-1:0] b_in,
  output logic [DATA_SIZE-1:0] a_out,
  output logic [DATA_SIZE-1:0] b_out,
  output logic [ACC_SIZE-1:0]  acc
);

  localparam int unsigned PW = 2 * DATA_SIZE;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;
  logic [PW-1:0]        prod;
  logic [ACC_SIZE-1:0]  prod_ext;

  always_comb begin
    a_x      = signed_mode ? PW'($signed(a_in)) : PW'(a_in);
    b_x      = signed_mode ? PW'($signed(b_in)) : PW'(b_in);
    prod     = a_x * b_x;
    prod_ext = signed_mode ? ACC_SIZE'($signed(prod)) : ACC_SIZE'(prod);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_out <= '0;
      b_out <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
    end
  end

`ifdef MATMUL_STREAM_SAT_EN
  logic [SAT_W-1:0] acc_x;
  logic [SAT_W-1:0] prod_x;
  logic [SAT_W-1:0] sum_raw;
  logic [SAT_W-1:0] sum_sat;
  logic             pinned;

  always_comb begin
    acc_x   = signed_mode ? SAT_W'($signed(acc)) : SAT_W'(acc);
    prod_x  = signed_mode ? SAT_W'($signed(prod_ext)) : SAT_W'(prod_ext);
    sum_raw = acc_x + prod_x;
    sum_sat = sat_add(acc_x, prod_x, ACC_SIZE, signed_mode);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc    <= '0;
      pinned <= 1'b0;
    end else if (en && !pinned) begin
      acc <= sum_sat[ACC_SIZE-1:0];
      if (sum_sat != sum_raw) pinned <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset || clear) acc <= '0;
    else if (en)        acc <= acc + prod_ext;
  end
`endif

endmodule

// File: rtl/matmul_stream_engine.sv
// Streaming N x N output-stationary systolic matrix multiplier, C = A * B over K beats.
// MATMUL_STREAM_SAT_EN enables saturating accumulation (default: wrap modulo 2^ACC_SIZE).
module matmul_stream_engine
  import matmul_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned ACC_SIZE  = 32,
  parameter int unsigned MAX_K     = 256,
  localparam int unsigned KW       = $clog2(MAX_K + 1),
  localparam int unsigned RW       = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  input  logic                      signed_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DATA_SIZE-1:0]    in_a,
  input  logic [N*DATA_SIZE-1:0]    in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*ACC_SIZE-1:0]     out_data,
  output logic [RW-1:0]             out_row,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned DRAIN_CYC = drain_len(N);
  localparam int unsigned DW        = $clog2(DRAIN_CYC);

  state_t        state;
  logic [KW-1:0] k_lat;
  logic [KW-1:0] k_cnt;
  logic [KW-1:0] k_clamped;
  logic [DW-1:0] drain_cnt;
  logic [RW-1:0] row;
  logic          sgn;
  logic          beat;
  logic          clear;
  logic          en;

  logic [DATA_SIZE-1:0] a_h   [N][N+1];
  logic [DATA_SIZE-1:0] b_v   [N+1][N];
  logic [ACC_SIZE-1:0]  acc_m [N][N];

  assign k_clamped = (k_len > KW'(MAX_K)) ? KW'(MAX_K) : k_len;
  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_OUTPUT);
  assign busy      = (state != ST_IDLE);
  assign beat      = in_valid && in_ready;
  assign clear     = (state == ST_IDLE) && start;
  assign en        = (state == ST_LOAD) || (state == ST_DRAIN);
  assign out_row   = row;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      k_lat     <= '0;
      k_cnt     <= '0;
      drain_cnt <= '0;
      row       <= '0;
      sgn       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          k_lat     <= k_clamped;
          sgn       <= signed_mode;
          k_cnt     <= '0;
          drain_cnt <= '0;
          row       <= '0;
          state     <= (k_clamped == '0) ? ST_OUTPUT : ST_LOAD;
        end
        ST_LOAD: if (beat) begin
          if (k_cnt == k_lat - 1'b1) state <= ST_DRAIN;
          else                       k_cnt <= k_cnt + 1'b1;
        end
        ST_DRAIN: begin
          if (drain_cnt == DW'(DRAIN_CYC - 1)) state <= ST_OUTPUT;
          else                                 drain_cnt <= drain_cnt + 1'b1;
        end
        ST_OUTPUT: if (out_ready) begin
          if (row == RW'(N - 1)) begin
            state <= ST_IDLE;
            row   <= '0;
            done  <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lane i is delayed i cycles so A[i][k] and B[k][j] meet in PE(i,j) together; idle cycles feed zeros.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DATA_SIZE-1:0] a_lane;
    logic [DATA_SIZE-1:0] b_lane;
    assign a_lane = beat ? in_a[i*DATA_SIZE +: DATA_SIZE] : '0;
    assign b_lane = beat ? in_b[i*DATA_SIZE +: DATA_SIZE] : '0;
    if (i == 0) begin : g_direct
      assign a_h[i][0] = a_lane;
      assign b_v[0][i] = b_lane;
    end else begin : g_delay
      logic [DATA_SIZE-1:0] a_sr [i];
      logic [DATA_SIZE-1:0] b_sr [i];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned s = 0; s < i; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else begin
          a_sr[0] <= a_lane;
          b_sr[0] <= b_lane;
          for (int unsigned s = 1; s < i; s++) begin
            a_sr[s] <= a_sr[s-1];
            b_sr[s] <= b_sr[s-1];
          end
        end
      end
      assign a_h[i][0] = a_sr[i-1];
      assign b_v[0][i] = b_sr[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      matmul_pe #(
        .DATA_SIZE (DATA_SIZE),
        .ACC_SIZE  (ACC_SIZE)
      ) u_pe (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .en          (en),
        .signed_mode (sgn),
        .a_in        (a_h[i][j]),
        .b_in        (b_v[i][j]),
        .a_out       (a_h[i][j+1]),
        .b_out       (b_v[i+1][j]),
        .acc         (acc_m[i][j])
      );
    end
  end

  always_comb begin
    out_data = '0;
    if (state == ST_OUTPUT) begin
      for (int unsigned j = 0; j < N; j++) out_data[j*ACC_SIZE +: ACC_SIZE] = acc_m[row][j];
    end
  end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// Directed table-driven bench for matmul_stream_engine (N=4, ACC_SIZE=16, MAX_K=8).
// Expected values for the saturation case follow MATMUL_STREAM_SAT_EN.
module tb_matmul_stream_engine;

  localparam int N    = 4;
  localparam int D    = 8;
  localparam int AW   = 16;
  localparam int MAXK = 8;
  localparam int KW   = $clog2(MAXK + 1);
  localparam int RW   = $clog2(N);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              signed_mode;
  logic              in_valid;
  logic              in_ready;
  logic [N*D-1:0]    in_a;
  logic [N*D-1:0]    in_b;
  logic              out_valid;
  logic              out_ready;
  logic [N*AW-1:0]   out_data;
  logic [RW-1:0]     out_row;
  logic              busy;
  logic              done;

  matmul_stream_engine #(
    .N         (N),
    .DATA_SIZE (D),
    .ACC_SIZE  (AW),
    .MAX_K     (MAXK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .k_len       (k_len),
    .signed_mode (signed_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row     (out_row),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                     k_len;
    bit                     sgn;
    logic [3:0][7:0][7:0]   a;   // a[i][k]
    logic [7:0][3:0][7:0]   b;   // b[k][j]
    logic [3:0][3:0][15:0]  c;   // c[r][j]
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  int cyc = 0;
  int done_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fill_uniform(input int v, input int k, input bit sgn,
                              input logic [7:0] av, input logic [7:0] bv, input logic [15:0] cv);
    vecs[v].k_len = k;
    vecs[v].sgn   = sgn;
    for (int i = 0; i < 4; i++)
      for (int k2 = 0; k2 < 8; k2++) begin
        vecs[v].a[i][k2] = av;
        vecs[v].b[k2][i] = bv;
      end
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) vecs[v].c[r][j] = cv;
  endtask

  // Runs one job from an IDLE slot; gaps throttles in_valid 1-of-2 and out_ready 1-of-3.
  task automatic run_job(input int v, input bit gaps, input bit poke_start);
    int kb, row, spins, cyc0, d0, exp_beats;
    logic [N*AW-1:0]  exp_row;
    logic [RW+N*AW-1:0] held;
    bit holding;
    exp_beats = (vecs[v].k_len > MAXK) ? MAXK : vecs[v].k_len;
    d0   = done_cnt;
    cyc0 = cyc;
    start       = 1'b1;
    k_len       = KW'(vecs[v].k_len);
    signed_mode = vecs[v].sgn;
    @(posedge clk); #1;
    start = 1'b0;
    kb = 0;
    spins = 0;
    while (in_ready && spins < 200) begin
      in_valid = gaps ? (spins % 2 == 0) : 1'b1;
      for (int i = 0; i < N; i++) begin
        in_a[i*D +: D] = vecs[v].a[i][kb & 7];
        in_b[i*D +: D] = vecs[v].b[kb & 7][i];
      end
      if (poke_start && spins == 1) begin
        start = 1'b1;
        k_len = KW'(1);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (in_valid) kb++;
      spins++;
    end
    check($sformatf("beats_v%0d", v), kb, exp_beats);
    in_valid = 1'b1;
    in_a     = '1;
    in_b     = '1;
    row = 0;
    spins = 0;
    holding = 1'b0;
    while (row < N && spins < 400) begin
      out_ready = gaps ? (spins % 3 == 0) : 1'b1;
      if (holding && out_valid) check($sformatf("stall_hold_v%0d", v), {out_row, out_data}, held);
      holding = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          for (int j = 0; j < N; j++) exp_row[j*AW +: AW] = vecs[v].c[row][j];
          check($sformatf("out_row_v%0d", v), out_row, row);
          check($sformatf("out_data_v%0d_r%0d", v, row), out_data, exp_row);
          row++;
        end else begin
          held    = {out_row, out_data};
          holding = 1'b1;
        end
      end
      @(posedge clk); #1;
      spins++;
    end
    out_ready = 1'b1;
    check($sformatf("rows_v%0d", v), row, N);
    check($sformatf("done_idle_v%0d", v), {done, busy}, 2'b10);
    if (!gaps && exp_beats > 0)
      check($sformatf("latency_v%0d", v), cyc - cyc0, exp_beats + 3 * N);
    @(posedge clk); #1;
    check($sformatf("done_low_v%0d", v), done, 1'b0);
    check($sformatf("done_once_v%0d", v), done_cnt - d0, 1);
  endtask

  initial begin
    int d;
    reset = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    fill_uniform(0, 4, 1'b0, 8'd1, 8'd2, 16'd8);
    fill_uniform(1, 4, 1'b0, 8'd0, 8'd0, 16'd0);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        vecs[1].a[i][k] = (i == k) ? 8'd1 : 8'd0;
        vecs[1].b[k][i] = 8'(4 * k + i);
        vecs[1].c[k][i] = 16'(4 * k + i);
      end
`ifdef MATMUL_STREAM_SAT_EN
    fill_uniform(2, 4, 1'b1, 8'd127, 8'd127, 16'h7FFF);
`else
    fill_uniform(2, 4, 1'b1, 8'd127, 8'd127, 16'hFC04);
`endif
    fill_uniform(3, 4, 1'b1, 8'hFF, 8'd3, 16'hFFF4);
    fill_uniform(4, 4, 1'b0, 8'hFF, 8'd3, 16'd3060);
    fill_uniform(5, 2, 1'b0, 8'd0, 8'd0, 16'd0);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 2; k++) begin
        vecs[5].a[i][k] = 8'(i + 1);
        vecs[5].b[k][i] = 8'(i + 1);
      end
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) vecs[5].c[r][j] = 16'(2 * (r + 1) * (j + 1));
    fill_uniform(6, 15, 1'b0, 8'd1, 8'd3, 16'd24);
    fill_uniform(7, 0, 1'b0, 8'd9, 8'd9, 16'd0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {in_ready, out_valid, busy, done}, 4'b0000);
    check("reset_data", {out_row, out_data}, '0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 1'b0);

    for (int v = 0; v < NV; v++) run_job(v, 1'b0, 1'b0);

    run_job(0, 1'b1, 1'b0);
    run_job(1, 1'b0, 1'b1);

    // Abort in LOAD after two beats; the following job must run as from power-up.
    d = done_cnt;
    start = 1'b1; k_len = KW'(4); signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) begin
        in_a[i*D +: D] = vecs[0].a[i][k];
        in_b[i*D +: D] = vecs[0].b[k][i];
      end
      @(posedge clk); #1;
    end
    check("abort_in_load", {busy, in_ready}, 2'b11);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_outs", {in_ready, out_valid, busy, done}, 4'b0000);
    check("abort_data", {out_row, out_data}, '0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d, 0);
    run_job(0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
